// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO over a valid/ready interface.
// tx_o comes straight from a flop so the pad never sees a combinational glitch.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic                         sys_clk_i,
  input  logic                         rst,
  input  logic [7:0]                   in_data_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  output logic                         tx_o,
  output logic                         tx_busy_o,
  output logic                         tx_done_o,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count_o
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [PTR_W:0]   FULL      = (PTR_W + 1)'(FIFO_DEPTH);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W:0]   count_q, count_d;

  logic push, pop, bit_end;

  assign in_ready_o   = (count_q != FULL);
  assign fifo_count_o = count_q;
  assign tx_o         = tx_q;
  assign tx_busy_o    = (state_q != S_IDLE);
  assign push         = in_valid_i && in_ready_o;
  assign bit_end      = (cnt_q == CNT_LAST);
  assign tx_done_o    = (state_q == S_STOP) && bit_end && (bit_q == STOP_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_q];
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        // bit_q counts stop bits here, so the baud counter stays one bit-period wide
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            if (count_q != '0) begin
              pop     = 1'b1;
              shift_d = mem_q[rd_q];
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase

    // tx is registered from the next state so it changes exactly on the transition edge
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    wr_d    = push ? wr_q + 1'b1 : wr_q;
    rd_d    = pop  ? rd_q + 1'b1 : rd_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    shift_q <= shift_d;
    if (push) mem_q[wr_q] <= in_data_i;
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a line-level receiver model per instance checks every
// cycle of each frame against bytes queued by the stimulus.
module tb_uart_tx_fifo;
  localparam int CPB_A = 868;
  localparam int LEN_A = 10 * CPB_A;
  localparam int CPB_C = 4;
  localparam int LEN_C = 11 * CPB_C;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  logic       rst_a, a_valid, a_ready, a_tx, a_busy, a_dn;
  logic [7:0] a_data;
  logic [2:0] a_cnt;
  logic       rst_c, c_valid, c_ready, c_tx, c_busy, c_dn;
  logic [7:0] c_data;
  logic [2:0] c_cnt;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB_A), .FIFO_DEPTH(4), .STOP_BITS(1)) dut_a (
    .sys_clk_i(clk), .rst(rst_a), .in_data_i(a_data), .in_valid_i(a_valid),
    .in_ready_o(a_ready), .tx_o(a_tx), .tx_busy_o(a_busy), .tx_done_o(a_dn),
    .fifo_count_o(a_cnt));

  uart_tx_fifo #(.CLKS_PER_BIT(CPB_C), .FIFO_DEPTH(4), .STOP_BITS(2)) dut_c (
    .sys_clk_i(clk), .rst(rst_c), .in_data_i(c_data), .in_valid_i(c_valid),
    .in_ready_o(c_ready), .tx_o(c_tx), .tx_busy_o(c_busy), .tx_done_o(c_dn),
    .fifo_count_o(c_cnt));

  logic [7:0] q_a[$];
  logic [7:0] q_c[$];
  longint     a_falls[$];
  longint     c_falls[$];
  longint     a_last_done = 0, c_last_done = 0;
  int a_t = 0, a_k = 0, a_bad = 0, a_frames = 0, a_dones = 0, a_idle_bad = 0;
  int c_t = 0, c_k = 0, c_bad = 0, c_frames = 0, c_dones = 0, c_idle_bad = 0;
  logic a_on = 1'b0, a_lvl = 1'b1, c_on = 1'b0, c_lvl = 1'b1;
  logic [7:0] a_exp = '0, a_got = '0, c_exp = '0, c_got = '0;
  logic [7:0] t3_bytes [6] = '{8'h3C, 8'hC3, 8'h00, 8'hFF, 8'h81, 8'h7E};

  // Receiver model for instance A (868 clocks/bit, one stop bit)
  initial forever begin
    @(negedge clk);
    if (rst_a) a_on = 1'b0;
    else begin
      if (a_dn) a_dones++;
      if (!a_on && a_tx === 1'b0) begin
        a_on = 1'b1; a_t = 0; a_bad = 0; a_got = '0;
        a_falls.push_back(cyc);
        if (q_a.size() == 0) begin chk("a_spurious_frame", 1, 0); a_exp = '0; end
        else a_exp = q_a.pop_front();
      end
      if (a_on) begin
        a_k = a_t / CPB_A;
        if (a_k == 0) a_lvl = 1'b0;
        else if (a_k <= 8) a_lvl = a_exp[a_k-1];
        else a_lvl = 1'b1;
        if (a_tx !== a_lvl || a_busy !== 1'b1 || a_dn !== (a_t == LEN_A - 1)) a_bad++;
        if (a_k >= 1 && a_k <= 8 && (a_t % CPB_A) == CPB_A / 2) a_got[a_k-1] = a_tx;
        if (a_t == LEN_A - 1) begin
          chk("a_byte", a_got, a_exp);
          chk("a_frame_cycles_bad", a_bad, 0);
          a_frames++; a_last_done = cyc; a_on = 1'b0;
        end
        a_t++;
      end else if (a_tx !== 1'b1 || a_busy !== 1'b0 || a_dn !== 1'b0) a_idle_bad++;
    end
  end

  // Receiver model for instance C (4 clocks/bit, two stop bits)
  initial forever begin
    @(negedge clk);
    if (rst_c) c_on = 1'b0;
    else begin
      if (c_dn) c_dones++;
      if (!c_on && c_tx === 1'b0) begin
        c_on = 1'b1; c_t = 0; c_bad = 0; c_got = '0;
        c_falls.push_back(cyc);
        if (q_c.size() == 0) begin chk("c_spurious_frame", 1, 0); c_exp = '0; end
        else c_exp = q_c.pop_front();
      end
      if (c_on) begin
        c_k = c_t / CPB_C;
        if (c_k == 0) c_lvl = 1'b0;
        else if (c_k <= 8) c_lvl = c_exp[c_k-1];
        else c_lvl = 1'b1;
        if (c_tx !== c_lvl || c_busy !== 1'b1 || c_dn !== (c_t == LEN_C - 1)) c_bad++;
        if (c_k >= 1 && c_k <= 8 && (c_t % CPB_C) == CPB_C / 2) c_got[c_k-1] = c_tx;
        if (c_t == LEN_C - 1) begin
          chk("c_byte", c_got, c_exp);
          chk("c_frame_cycles_bad", c_bad, 0);
          c_frames++; c_last_done = cyc; c_on = 1'b0;
        end
        c_t++;
      end else if (c_tx !== 1'b1 || c_busy !== 1'b0 || c_dn !== 1'b0) c_idle_bad++;
    end
  end

  task automatic wait_frames_a(input int n, input int lim);
    int g = 0;
    while (a_frames < n && g < lim) begin @(negedge clk); g++; end
    chk("a_frames_reached", a_frames >= n, 1);
  endtask

  task automatic wait_frames_c(input int n, input int lim);
    int g = 0;
    while (c_frames < n && g < lim) begin @(negedge clk); g++; end
    chk("c_frames_reached", c_frames >= n, 1);
  endtask

  longint t_push;
  int nf, f0, d0, peak, idx, g;
  logic saw_full, full_before6;

  initial begin
    rst_a = 1'b1; rst_c = 1'b1;
    a_valid = 1'b0; c_valid = 1'b0; a_data = '0; c_data = '0;
    repeat (3) @(negedge clk);
    rst_a = 1'b0; rst_c = 1'b0;
    chk("rst_tx", a_tx, 1);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_dn, 0);
    chk("rst_count", a_cnt, 0);
    chk("rst_ready", a_ready, 1);
    chk("rst_c_tx", c_tx, 1);

    // Single byte: latency, frame shape, done position, return to idle
    @(negedge clk);
    nf = a_falls.size(); d0 = a_dones;
    a_data = 8'h01; a_valid = 1'b1; t_push = cyc; q_a.push_back(8'h01);
    @(negedge clk);
    a_valid = 1'b0; a_data = 8'hEE;
    wait_frames_a(1, LEN_A + 50);
    chk("t1_fall_latency", (a_falls.size() > nf) ? a_falls[nf] - t_push : -1, 2);
    chk("t1_done_offset", (a_falls.size() > nf) ? a_last_done - a_falls[nf] : -1, LEN_A - 1);
    repeat (5) @(negedge clk);
    chk("t1_tx_idle", a_tx, 1);
    chk("t1_busy_idle", a_busy, 0);
    chk("t1_done_pulses", a_dones - d0, 1);

    // Four consecutive pushes: back-to-back frames
    f0 = a_frames; nf = a_falls.size(); d0 = a_dones;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_data = 8'(i + 1); a_valid = 1'b1;
      chk("t2_ready", a_ready, 1);
      q_a.push_back(8'(i + 1));
    end
    @(negedge clk);
    a_valid = 1'b0;
    wait_frames_a(f0 + 4, 4 * LEN_A + 100);
    chk("t2_frame_starts", a_falls.size() - nf, 4);
    if (a_falls.size() >= nf + 4) begin
      chk("t2_total_cycles", a_last_done - a_falls[nf] + 1, 4 * LEN_A);
      for (int i = 1; i < 4; i++) chk("t2_gap", a_falls[nf+i] - a_falls[nf+i-1], LEN_A);
    end
    repeat (3) @(negedge clk);
    chk("t2_done_pulses", a_dones - d0, 4);
    chk("t2_queue_drained", q_a.size(), 0);

    // Reset 3000 cycles into frame 0xA5 with 0x33 still queued
    nf = a_falls.size(); d0 = a_dones;
    @(negedge clk);
    a_data = 8'hA5; a_valid = 1'b1; q_a.push_back(8'hA5);
    @(negedge clk);
    a_data = 8'h33; q_a.push_back(8'h33);
    @(negedge clk);
    a_valid = 1'b0;
    g = 0;
    while (a_falls.size() <= nf && g < 100) begin @(negedge clk); g++; end
    chk("t4_frame_started", a_falls.size() > nf, 1);
    if (a_falls.size() > nf)
      while (cyc < a_falls[nf] + 3000) @(negedge clk);
    chk("t4_count_before", a_cnt, 1);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    chk("t4_tx_after_rst", a_tx, 1);
    chk("t4_busy_after_rst", a_busy, 0);
    chk("t4_count_after_rst", a_cnt, 0);
    chk("t4_ready_after_rst", a_ready, 1);
    q_a.delete();
    repeat (20) @(negedge clk);
    chk("t4_no_done", a_dones - d0, 0);
    f0 = a_frames;
    a_data = 8'h5A; a_valid = 1'b1; q_a.push_back(8'h5A);
    @(negedge clk);
    a_valid = 1'b0;
    wait_frames_a(f0 + 1, LEN_A + 50);
    repeat (3) @(negedge clk);
    chk("t4_done_pulses", a_dones - d0, 1);
    chk("t4_queue_drained", q_a.size(), 0);

    // Two stop bits, 4 clocks per bit, byte 0xFF
    nf = c_falls.size(); f0 = c_frames; d0 = c_dones;
    @(negedge clk);
    c_data = 8'hFF; c_valid = 1'b1; q_c.push_back(8'hFF);
    @(negedge clk);
    c_valid = 1'b0;
    wait_frames_c(f0 + 1, 200);
    chk("t5_frame_len", (c_falls.size() > nf) ? c_last_done - c_falls[nf] + 1 : -1, 44);
    repeat (3) @(negedge clk);
    chk("t5_done_pulses", c_dones - d0, 1);

    // Six bytes with valid held high: FIFO fills and back-pressures
    f0 = c_frames; d0 = c_dones; peak = 0; idx = 0; g = 0;
    saw_full = 1'b0; full_before6 = 1'b0;
    @(negedge clk);
    while (idx < 6 && g < 2000) begin
      c_data = t3_bytes[idx]; c_valid = 1'b1;
      if (int'(c_cnt) > peak) peak = int'(c_cnt);
      if (!c_ready) saw_full = 1'b1;
      else begin
        if (idx == 5) full_before6 = saw_full;
        q_c.push_back(t3_bytes[idx]);
        idx++;
      end
      @(negedge clk); g++;
    end
    c_valid = 1'b0;
    chk("t3_pushed", idx, 6);
    chk("t3_peak_count", peak, 4);
    chk("t3_ready_low_before_6th", full_before6, 1);
    wait_frames_c(f0 + 6, 6 * LEN_C + 200);
    repeat (3) @(negedge clk);
    chk("t3_done_pulses", c_dones - d0, 6);
    chk("t3_queue_drained", q_c.size(), 0);

    chk("a_idle_cycles_bad", a_idle_bad, 0);
    chk("c_idle_cycles_bad", c_idle_bad, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
